// File: rtl/filter_float.sv
// Streaming FIR filter on IEEE-754 single-precision samples.
// One sequential multiply and one add per tap, accumulating in ascending tap order.
module filter_float #(
  parameter int unsigned        TAPS = 4,
  parameter logic [TAPS*32-1:0] COEF = {4{32'h3E800000}}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inSignalUnReg,
  input  logic        newData,
  output logic [31:0] outSignal,
  output logic        dataReady
);

  localparam int unsigned   KW       = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned   CW       = $clog2(TAPS * 32);
  localparam logic [KW-1:0] LAST_TAP = KW'(TAPS - 1);

  typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} stateT;

  // Truncating float multiply; zero/denormal operands give +0, exponent 0xFF gives signed infinity.
  function automatic logic [31:0] fMul(input logic [31:0] a, input logic [31:0] b);
    logic        sgn;
    logic [24:0] pHi;
    logic [22:0] frac;
    int          e;
    sgn = a[31] ^ b[31];
    pHi = 25'((48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]})) >> 23);
    e   = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (pHi[24]) begin
      frac = pHi[23:1];
      e    = e + 1;
    end else begin
      frac = pHi[22:0];
    end
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) fMul = {sgn, 8'hFF, 23'd0};
    else if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 0) fMul = 32'd0;
    else if (e >= 255) fMul = {sgn, 8'hFF, 23'd0};
    else fMul = {sgn, 8'(e), frac};
  endfunction

  // Truncating float add; the smaller magnitude is aligned by right shift, bits shifted out are lost.
  function automatic logic [31:0] fAdd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] big;
    logic [31:0] sml;
    logic [7:0]  shift;
    logic [23:0] mSml;
    logic [23:0] diff;
    logic [24:0] sum;
    logic [22:0] frac;
    int          e;
    int          lz;
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    shift = big[30:23] - sml[30:23];
    mSml  = {1'b1, sml[22:0]} >> shift;
    sum   = 25'({1'b1, big[22:0]}) + 25'(mSml);
    diff  = {1'b1, big[22:0]} - mSml;
    lz    = 0;
    for (int i = 0; i < 24; i++) begin
      if (diff[i]) lz = 23 - i;
    end
    if (big[31] == sml[31]) begin
      if (sum[24]) begin
        frac = sum[23:1];
        e    = int'(big[30:23]) + 1;
      end else begin
        frac = sum[22:0];
        e    = int'(big[30:23]);
      end
    end else begin
      frac = 23'(diff << lz);
      e    = int'(big[30:23]) - lz;
    end
    if (a[30:23] == 8'hFF) fAdd = {a[31], 8'hFF, 23'd0};
    else if (b[30:23] == 8'hFF) fAdd = {b[31], 8'hFF, 23'd0};
    else if (a[30:23] == 8'd0) fAdd = (b[30:23] == 8'd0) ? 32'd0 : b;
    else if (b[30:23] == 8'd0) fAdd = a;
    else if (big[31] != sml[31] && diff == 24'd0) fAdd = 32'd0;
    else if (e <= 0) fAdd = 32'd0;
    else if (e >= 255) fAdd = {big[31], 8'hFF, 23'd0};
    else fAdd = {big[31], 8'(e), frac};
  endfunction

  stateT         state;
  stateT         stateNext;
  logic [31:0]   x [TAPS];
  logic [31:0]   acc;
  logic [31:0]   prod;
  logic [31:0]   coefSel;
  logic [CW-1:0] coefIdx;
  logic [KW-1:0] k;
  logic          newDataQ;
  logic          risingEdge;

  assign risingEdge = newData & ~newDataQ;
  assign coefIdx    = CW'({k, 5'd0});
  assign coefSel    = COEF[coefIdx +: 32];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (risingEdge) stateNext = MUL;
      MUL:     stateNext = ADD;
      ADD:     stateNext = (k == LAST_TAP) ? DONE : MUL;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Delay line, MAC datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) x[i] <= 32'd0;
      acc       <= 32'd0;
      prod      <= 32'd0;
      k         <= '0;
      newDataQ  <= 1'b0;
      outSignal <= 32'd0;
      dataReady <= 1'b0;
    end else begin
      newDataQ  <= newData;
      dataReady <= 1'b0;
      case (state)
        IDLE: begin
          if (risingEdge) begin
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            x[0] <= inSignalUnReg;
            acc  <= 32'd0;
            k    <= '0;
          end
        end
        MUL: prod <= fMul(coefSel, x[k]);
        ADD: begin
          acc <= fAdd(acc, prod);
          if (k != LAST_TAP) k <= k + KW'(1);
        end
        DONE: begin
          outSignal <= acc;
          dataReady <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_float.sv
// Scoreboard bench for filter_float: a real-valued FIR model predicts each result,
// a forked monitor checks value and latency on every dataReady pulse.
module tb_filter_float;

  localparam int unsigned        TAPS = 4;
  localparam int                 LAT  = 2 * TAPS + 2;
  localparam logic [TAPS*32-1:0] COEF = {4{32'h3E800000}};

  logic        clk           = 1'b0;
  logic        rst           = 1'b1;
  logic [31:0] inSignalUnReg = 32'd0;
  logic        newData       = 1'b0;
  logic [31:0] outSignal;
  logic        dataReady;

  typedef struct {
    real val;
    int  issue;
  } expT;

  int  cyc        = 0;
  int  nChecks    = 0;
  int  nFails     = 0;
  int  lastAccept = -1000;
  expT sbq[$];
  real hist[$];
  real coefR[TAPS];

  filter_float #(.TAPS(TAPS), .COEF(COEF)) dut (
    .clk          (clk),
    .rst          (rst),
    .inSignalUnReg(inSignalUnReg),
    .newData      (newData),
    .outSignal    (outSignal),
    .dataReady    (dataReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real f2r(input logic [31:0] b);
    real r;
    if (b[30:23] == 8'd0) return 0.0;
    r = real'(int'({1'b1, b[22:0]})) * pow2(int'(b[30:23]) - 150);
    return b[31] ? -r : r;
  endfunction

  function automatic real ulpOf(input real v);
    real a = (v < 0.0) ? -v : v;
    int  e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    return pow2(e - 23);
  endfunction

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkBits(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] act, input real exp);
    real err;
    bit  ok;
    nChecks++;
    if (exp == 0.0) begin
      ok = (act == 32'h0);
    end else begin
      err = f2r(act) - exp;
      if (err < 0.0) err = -err;
      ok = (act[30:23] != 8'hFF) && (err <= 2.0 * ulpOf(exp));
    end
    if (!ok) begin
      nFails++;
      $display("FAIL %s: got %h (%f), want %f within 2 ulp (cycle %0d)", name, act, f2r(act), exp, cyc);
    end
  endtask

  // Drive one rising edge; the model accepts it only if the filter is idle.
  task automatic sendEdge(input logic [31:0] s, input int hold);
    real y;
    inSignalUnReg = s;
    newData       = 1'b1;
    if (cyc - lastAccept >= LAT) begin
      hist.push_front(f2r(s));
      if (hist.size() > TAPS) void'(hist.pop_back());
      y = 0.0;
      foreach (hist[i]) y = y + coefR[i] * hist[i];
      sbq.push_back('{val: y, issue: cyc});
      lastAccept = cyc;
    end
    waitCycles(hold);
    newData = 1'b0;
  endtask

  task automatic doReset(input int n);
    rst = 1'b1;
    sbq.delete();
    hist.delete();
    waitCycles(n);
    rst        = 1'b0;
    lastAccept = -1000;
    waitCycles(1);
  endtask

  task automatic monitor();
    expT e;
    forever begin
      @(negedge clk);
      if (dataReady === 1'b1) begin
        if (sbq.size() == 0) begin
          nChecks++;
          nFails++;
          $display("FAIL spurious_pulse: dataReady=1, want 0 (no sample pending, cycle %0d)", cyc);
        end else begin
          e = sbq.pop_front();
          checkInt("latency", cyc - e.issue, LAT);
          checkVal("output", outSignal, e.val);
        end
      end
    end
  endtask

  initial begin
    logic [31:0] stepExp [4];
    logic [31:0] mixed [10];
    logic [31:0] v;
    int          gap;
    int          hold;

    stepExp = '{32'h3E800000, 32'h3F000000, 32'h3F400000, 32'h3F800000};
    mixed   = '{32'hBF83C6E0, 32'h4141669E, 32'h40039B58, 32'h40B32045, 32'h412A09E2,
                32'h40EC34B1, 32'h414545AD, 32'h417FDF8A, 32'hBEDC3A8C, 32'h3F2D6547};
    for (int i = 0; i < TAPS; i++) coefR[i] = f2r(32'(COEF >> (32 * i)));

    fork
      monitor();
    join_none

    // Reset held 25 cycles while newData toggles.
    rst = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      newData = (i < 20) ? ~newData : 1'b0;
    end
    checkBits("reset_out", outSignal, 32'h0);
    checkInt("reset_ready", int'(dataReady), 0);
    rst        = 1'b0;
    lastAccept = -1000;
    waitCycles(5);
    checkBits("post_reset_out", outSignal, 32'h0);

    // Unit step, 250 cycles between samples.
    for (int i = 0; i < 4; i++) begin
      sendEdge(32'h3F800000, 12);
      waitCycles(238);
      checkBits("step_hold", outSignal, stepExp[i]);
    end

    // Impulse with negative sign, then the tail drains to +0.
    doReset(3);
    sendEdge(32'hBF83C6E0, 2);
    waitCycles(18);
    checkBits("impulse", outSignal, 32'hBE83C6E0);
    for (int i = 0; i < 3; i++) begin
      sendEdge(32'h00000000, 2);
      waitCycles(18);
      checkBits("impulse_tap", outSignal, 32'hBE83C6E0);
    end
    sendEdge(32'h00000000, 2);
    waitCycles(18);
    checkBits("impulse_tail", outSignal, 32'h00000000);

    // Mixed sequence against the real-valued model.
    doReset(3);
    for (int i = 0; i < 10; i++) begin
      sendEdge(mixed[i], 3);
      waitCycles(17);
    end

    // Edge while busy is dropped; a held level gives one result only.
    doReset(3);
    sendEdge(32'h40400000, 1);
    waitCycles(2);
    sendEdge(32'h41200000, 4);
    waitCycles(20);
    sendEdge(32'h3F800000, 500);
    waitCycles(5);
    sendEdge(32'h40000000, 2);
    waitCycles(18);
    checkBits("dropped_edge_hist", outSignal, 32'h3FC00000);

    // Reset four cycles after an accepted edge aborts the computation.
    sendEdge(32'h40800000, 1);
    waitCycles(3);
    rst = 1'b1;
    sbq.delete();
    hist.delete();
    waitCycles(3);
    rst        = 1'b0;
    lastAccept = -1000;
    waitCycles(2);
    checkBits("midreset_out", outSignal, 32'h0);
    checkInt("midreset_ready", int'(dataReady), 0);
    sendEdge(32'h40A00000, 2);
    waitCycles(18);
    checkBits("after_midreset", outSignal, 32'h3FA00000);

    // Random samples with random spacing, some inside the busy window.
    doReset(3);
    for (int n = 0; n < 80; n++) begin
      v = {1'($urandom_range(0, 1)), 8'($urandom_range(126, 130)), 12'($urandom), 11'd0};
      if ($urandom_range(0, 9) == 0) v = 32'h0;
      gap  = $urandom_range(2, 14);
      hold = $urandom_range(1, gap - 1);
      sendEdge(v, hold);
      waitCycles(gap - hold);
    end

    for (int i = 0; i < 100 && sbq.size() > 0; i++) waitCycles(1);
    checkInt("drain_pending", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
